// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI opcodes, frame bit positions and responder state encoding
package spi_pkg;

   localparam logic [7:0] READ_CMD  = 8'h03;
   localparam logic [7:0] WRITE_CMD = 8'h02;

   localparam int CMD_BITS  = 8;
   localparam int ADDR_BITS = 16;
   localparam int TURN_BIT  = 24;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CMD     = 3'd1,
      ST_ADDR    = 3'd2,
      ST_TURN    = 3'd3,
      ST_RD_DATA = 3'd4,
      ST_WR_DATA = 3'd5,
      ST_IGNORE  = 3'd6
   } resp_state_e;

endpackage

// File: rtl/spi_shift8.sv
// rtl/spi_shift8.sv - 8-bit shift register with parallel load, serial in and bit-7 count flag
module spi_shift8 (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       clear_i,
   input  logic       load_i,
   input  logic       shift_i,
   input  logic [7:0] data_i,
   input  logic       sdi_i,
   output logic [7:0] q_o,
   output logic       cnt7_o
);

   logic [7:0] data_q, data_d;
   logic [2:0] cnt_q, cnt_d;

   always_comb begin
      data_d = data_q;
      cnt_d  = cnt_q;
      if (clear_i) begin
         data_d = '0;
         cnt_d  = '0;
      end else if (load_i) begin
         data_d = data_i;
         cnt_d  = '0;
      end else if (shift_i) begin
         data_d = {data_q[6:0], sdi_i};
         cnt_d  = cnt_q + 3'd1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         data_q <= '0;
         cnt_q  <= '0;
      end else begin
         data_q <= data_d;
         cnt_q  <= cnt_d;
      end
   end

   assign q_o    = data_q;
   // High on the edge that completes a byte (shift) or ends a transmitted byte (reload).
   assign cnt7_o = (cnt_q == 3'd7);

endmodule

// File: rtl/spi_mem_responder.sv
// rtl/spi_mem_responder.sv - SPI slave exposing a byte memory via READ/WRITE streaming frames
module spi_mem_responder #(
   parameter logic [7:0] READ_CMD  = spi_pkg::READ_CMD,
   parameter logic [7:0] WRITE_CMD = spi_pkg::WRITE_CMD
) (
   input  logic        sclk,
   input  logic        rst,
   input  logic        cs,
   input  logic        mosi,
   output logic        miso,
   output logic [15:0] mem_addr,
   input  logic [7:0]  mem_rdata,
   output logic [7:0]  mem_wdata,
   output logic        mem_we,
   output logic        busy
);
   import spi_pkg::*;

   localparam logic [4:0] B_CMD_LAST  = 5'(CMD_BITS - 1);
   localparam logic [4:0] B_ADDR_HI   = 5'(CMD_BITS + 8);
   localparam logic [4:0] B_ADDR_LAST = 5'(CMD_BITS + ADDR_BITS - 1);
   localparam logic [4:0] B_TURN      = 5'(TURN_BIT);

   resp_state_e state_q, state_d;
   logic [4:0]  bit_q, bit_d;
   logic        is_read_q, is_read_d;
   logic [7:0]  addr_hi_q, addr_hi_d;
   logic [15:0] mem_addr_q, mem_addr_d;
   logic [7:0]  mem_wdata_q, mem_wdata_d;
   logic        mem_we_q, mem_we_d;

   logic        rx_shift, rx_cnt7;
   logic [7:0]  rx_q, rx_byte;
   logic        tx_load, tx_shift, tx_cnt7;
   logic [7:0]  tx_q;
   logic        unused_tx;

   spi_shift8 u_rx (
      .clk_i   (sclk),
      .rst_i   (rst),
      .clear_i (cs),
      .load_i  (1'b0),
      .shift_i (rx_shift),
      .data_i  (8'h00),
      .sdi_i   (mosi),
      .q_o     (rx_q),
      .cnt7_o  (rx_cnt7)
   );

   spi_shift8 u_tx (
      .clk_i   (sclk),
      .rst_i   (rst),
      .clear_i (cs),
      .load_i  (tx_load),
      .shift_i (tx_shift),
      .data_i  (mem_rdata),
      .sdi_i   (1'b0),
      .q_o     (tx_q),
      .cnt7_o  (tx_cnt7)
   );

   // Byte including the bit being sampled on this edge.
   assign rx_byte   = {rx_q[6:0], mosi};
   assign unused_tx = ^tx_q[6:0];

   always_comb begin
      state_d     = state_q;
      bit_d       = bit_q;
      is_read_d   = is_read_q;
      addr_hi_d   = addr_hi_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_we_d    = 1'b0;
      rx_shift    = 1'b0;
      tx_load     = 1'b0;
      tx_shift    = 1'b0;
      if (cs) begin
         state_d = ST_IDLE;
         bit_d   = '0;
      end else begin
         if (bit_q != B_TURN) bit_d = bit_q + 5'd1;
         case (state_q)
            ST_IDLE: begin
               rx_shift = 1'b1;
               state_d  = ST_CMD;
            end
            ST_CMD: begin
               rx_shift = 1'b1;
               if (bit_q == B_CMD_LAST) begin
                  if (rx_byte == READ_CMD) begin
                     state_d   = ST_ADDR;
                     is_read_d = 1'b1;
                  end else if (rx_byte == WRITE_CMD) begin
                     state_d   = ST_ADDR;
                     is_read_d = 1'b0;
                  end else begin
                     state_d   = ST_IGNORE;
                  end
               end
            end
            ST_ADDR: begin
               rx_shift = 1'b1;
               if (bit_q == B_ADDR_HI) addr_hi_d = rx_q;
               if (bit_q == B_ADDR_LAST) begin
                  mem_addr_d = {addr_hi_q, rx_byte};
                  state_d    = is_read_q ? ST_TURN : ST_WR_DATA;
               end
            end
            ST_TURN: begin
               tx_load    = 1'b1;
               mem_addr_d = mem_addr_q + 16'd1;
               state_d    = ST_RD_DATA;
            end
            ST_RD_DATA: begin
               if (tx_cnt7) begin
                  tx_load    = 1'b1;
                  mem_addr_d = mem_addr_q + 16'd1;
               end else begin
                  tx_shift   = 1'b1;
               end
            end
            ST_WR_DATA: begin
               rx_shift = 1'b1;
               if (mem_we_q) mem_addr_d = mem_addr_q + 16'd1;
               if (rx_cnt7) begin
                  mem_wdata_d = rx_byte;
                  mem_we_d    = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge sclk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         bit_q       <= '0;
         is_read_q   <= 1'b0;
         addr_hi_q   <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_we_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_q       <= bit_d;
         is_read_q   <= is_read_d;
         addr_hi_q   <= addr_hi_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_we_q    <= mem_we_d;
      end
   end

   assign miso      = tx_q[7];
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_we    = mem_we_q;
   assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_mem_responder.sv
// tb/tb_spi_mem_responder.sv - directed and randomized self-checking bench for spi_mem_responder
module tb_spi_mem_responder;

   logic        sclk = 1'b0;
   logic        rst, cs, mosi, miso, mem_we, busy;
   logic [15:0] mem_addr;
   logic [7:0]  mem_rdata, mem_wdata;

   logic [7:0]  mem     [0:65535];
   logic [7:0]  ref_mem [0:65535];
   logic [23:0] wr_log  [$];
   int          n_assert = 0;
   int          n_fail   = 0;

   spi_mem_responder dut (
      .sclk      (sclk),
      .rst       (rst),
      .cs        (cs),
      .mosi      (mosi),
      .miso      (miso),
      .mem_addr  (mem_addr),
      .mem_rdata (mem_rdata),
      .mem_wdata (mem_wdata),
      .mem_we    (mem_we),
      .busy      (busy)
   );

   always #5 sclk = ~sclk;

   assign mem_rdata = mem[mem_addr];
   always @(posedge sclk) if (mem_we) mem[mem_addr] <= mem_wdata;
   always @(negedge sclk) if (mem_we) wr_log.push_back({mem_addr, mem_wdata});

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      cs = 1'b0;
      mosi = b;
      @(posedge sclk);
      @(negedge sclk);
   endtask

   task automatic send_byte(input logic [7:0] v);
      for (int i = 7; i >= 0; i--) send_bit(v[i]);
   endtask

   task automatic end_frame();
      cs = 1'b1;
      mosi = 1'b0;
      @(posedge sclk);
      @(negedge sclk);
   endtask

   task automatic do_read(input logic [15:0] a, input int nbytes, input string tag);
      logic [7:0] got;
      send_byte(8'h03);
      send_byte(a[15:8]);
      send_byte(a[7:0]);
      send_bit(1'($urandom_range(0, 1)));
      for (int n = 0; n < nbytes; n++) begin
         got = '0;
         for (int k = 7; k >= 0; k--) begin
            got[k] = miso;
            if (!(n == nbytes - 1 && k == 0)) send_bit(1'($urandom_range(0, 1)));
         end
         chk({tag, " data"}, 32'(got), 32'(ref_mem[16'(a + 16'(n))]));
      end
      end_frame();
      chk({tag, " end addr"}, 32'(mem_addr), 32'(16'(a + 16'(nbytes))));
   endtask

   task automatic do_write(input logic [15:0] a, input logic [7:0] d[$], input int extra, input string tag);
      logic [15:0] exp_end;
      wr_log.delete();
      send_byte(8'h02);
      send_byte(a[15:8]);
      send_byte(a[7:0]);
      foreach (d[i]) send_byte(d[i]);
      for (int i = 0; i < extra; i++) send_bit(1'($urandom_range(0, 1)));
      end_frame();
      foreach (d[i]) ref_mem[16'(a + 16'(i))] = d[i];
      chk({tag, " write count"}, 32'(wr_log.size()), 32'(d.size()));
      foreach (d[i])
         if (i < wr_log.size())
            chk({tag, " write event"}, 32'(wr_log[i]), 32'({16'(a + 16'(i)), d[i]}));
      exp_end = (extra > 0) ? 16'(a + 16'(d.size())) : 16'(a + 16'(d.size()) - 16'd1);
      chk({tag, " end addr"}, 32'(mem_addr), 32'(exp_end));
   endtask

   initial begin
      logic [7:0]  wd[$];
      logic [15:0] last_wr, ra;
      int          bad;

      for (int i = 0; i < 65536; i++) begin
         mem[i]     = 8'($urandom);
         ref_mem[i] = mem[i];
      end
      rst = 1'b1;
      cs = 1'b1;
      mosi = 1'b0;
      #12;
      chk("reset miso", 32'(miso), 32'd0);
      chk("reset mem_addr", 32'(mem_addr), 32'd0);
      chk("reset mem_we", 32'(mem_we), 32'd0);
      chk("reset mem_wdata", 32'(mem_wdata), 32'd0);
      chk("reset busy", 32'(busy), 32'd0);
      @(negedge sclk);
      rst = 1'b0;
      end_frame();

      mem[16'h1234] = 8'hA5; ref_mem[16'h1234] = 8'hA5;
      mem[16'h1235] = 8'h3C; ref_mem[16'h1235] = 8'h3C;
      do_read(16'h1234, 2, "read 1234");
      do_read(16'hFFFF, 2, "read wrap");

      wd = '{8'hDE, 8'hAD};
      do_write(16'h0100, wd, 5, "write 0100");
      do_read(16'h0100, 2, "readback 0100");

      wd = '{8'h11};
      do_write(16'h2000, wd, 0, "write cs at drop");
      wd = '{8'h77, 8'h88};
      do_write(16'hFFFF, wd, 3, "write wrap");
      do_read(16'hFFFF, 2, "readback wrap");

      wd = '{};
      do_write(16'h3000, wd, 7, "partial byte");

      wr_log.delete();
      bad = 0;
      send_byte(8'h9F);
      for (int i = 0; i < 24; i++) begin
         send_bit(1'($urandom_range(0, 1)));
         if (miso !== 1'b0 || busy !== 1'b1) bad++;
      end
      chk("ignore miso/busy", 32'(bad), 32'd0);
      end_frame();
      chk("ignore busy after cs", 32'(busy), 32'd0);
      chk("ignore no write", 32'(wr_log.size()), 32'd0);
      do_read(16'h1234, 1, "read after ignore");

      send_byte(8'h02);
      send_byte(8'h40);
      send_byte(8'h00);
      send_byte(8'h5A);
      chk("pre-reset mem_we", 32'(mem_we), 32'd1);
      chk("pre-reset mem_addr", 32'(mem_addr), 32'h4000);
      #2 rst = 1'b1;
      #1;
      chk("mid-frame reset miso", 32'(miso), 32'd0);
      chk("mid-frame reset mem_we", 32'(mem_we), 32'd0);
      chk("mid-frame reset mem_addr", 32'(mem_addr), 32'd0);
      chk("mid-frame reset busy", 32'(busy), 32'd0);
      @(negedge sclk);
      rst = 1'b0;
      cs = 1'b1;
      end_frame();
      do_read(16'h4000, 1, "read after reset");

      last_wr = 16'h0100;
      for (int it = 0; it < 100; it++) begin
         if ($urandom_range(0, 2) == 0) begin
            wd = '{};
            for (int j = 0; j < int'($urandom_range(1, 3)); j++) wd.push_back(8'($urandom));
            last_wr = 16'($urandom);
            do_write(last_wr, wd, int'($urandom_range(0, 7)), "rand write");
         end
         ra = ($urandom_range(0, 1) == 0) ? last_wr : 16'($urandom);
         do_read(ra, int'($urandom_range(1, 3)), "rand read");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
